// File: rtl/jtag_bridge_pkg.sv
// Shared definitions for the virtual-JTAG scan bridge: instruction codes,
// status/counter widths and the per-instruction chain length.
package jtag_bridge_pkg;

    typedef enum logic [2:0] {
        INSTR_BYPASS = 3'd0,
        INSTR_WRITE  = 3'd1,
        INSTR_READ   = 3'd2,
        INSTR_RW     = 3'd3,
        INSTR_STATUS = 3'd4
    } instr_t;

    localparam int STATUS_W = 16;
    localparam int CNT_W    = 7;

    function automatic int chain_len(input instr_t instr, input int n_in, input int n_out);
        case (instr)
            INSTR_WRITE:  return n_in;
            INSTR_READ:   return n_out;
            INSTR_RW:     return (n_in > n_out) ? n_in : n_out;
            INSTR_STATUS: return STATUS_W;
            default:      return 1;
        endcase
    endfunction

    // Codes 5..7 are unassigned and fold onto BYPASS.
    function automatic instr_t decode_instr(input logic [2:0] code);
        if (code > 3'd4) begin
            return INSTR_BYPASS;
        end
        return instr_t'(code);
    endfunction

endpackage

// File: rtl/jtag_shift_chain.sv
// W-bit scan chain: parallel capture of the DUT result and right shift with
// an instruction-dependent insertion point.
module jtag_shift_chain
    import jtag_bridge_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 6
) (
    input  logic                                   tck,
    input  logic                                   reset,
    input  logic                                   capture_en,
    input  logic                                   shift_en,
    input  logic [2:0]                             instr,
    input  logic                                   tdi,
    input  logic [N_OUT-1:0]                       dut_output,
    output logic [((N_IN > N_OUT) ? N_IN : N_OUT)-1:0] chain
);

    localparam int W = (N_IN > N_OUT) ? N_IN : N_OUT;

    logic [W-1:0] chain_q;
    logic [W-1:0] chain_d;

    always_comb begin
        chain_d = chain_q;
        if (capture_en) begin
            case (instr)
                INSTR_READ, INSTR_RW: begin
                    chain_d                = '0;
                    chain_d[N_OUT-1:0]     = dut_output;
                end
                INSTR_WRITE: chain_d = '0;
                default: ;
            endcase
        end else if (shift_en) begin
            // Each instruction inserts at the top of its own chain length.
            case (instr)
                INSTR_WRITE: begin
                    chain_d           = chain_q >> 1;
                    chain_d[N_IN-1]   = tdi;
                end
                INSTR_READ: begin
                    chain_d           = chain_q >> 1;
                    chain_d[N_OUT-1]  = 1'b0;
                end
                INSTR_RW: begin
                    chain_d           = chain_q >> 1;
                    chain_d[W-1]      = tdi;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign chain = chain_q;

endmodule

// File: rtl/jtag_scan_bridge.sv
// Virtual-JTAG scan bridge between v_jtag TDI/TDO and DUT parallel vectors.
// Optional scan-length checking is enabled with `define SCAN_LEN_CHECK_EN.
module jtag_scan_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 6,
    parameter int IR_W  = 3
) (
    input  logic             tck,
    input  logic             reset,
    input  logic             tdi,
    output logic             tdo,
    input  logic [IR_W-1:0]  ir_in,
    input  logic             cdr,
    input  logic             sdr,
    input  logic             udr,
    output logic [N_IN-1:0]  dut_input,
    input  logic [N_OUT-1:0] dut_output,
    output logic             dut_strobe,
    output logic [4:0]       state_out
);

    localparam int W = (N_IN > N_OUT) ? N_IN : N_OUT;

    logic update_en;
    logic capture_en;
    logic shift_en;
    assign update_en  = udr;
    assign capture_en = cdr & ~udr;
    assign shift_en   = sdr & ~udr & ~cdr;

    instr_t ir_mode;
    instr_t mode_q, mode_d;
    instr_t chain_instr;
    assign ir_mode     = decode_instr(ir_in[2:0]);
    assign chain_instr = capture_en ? ir_mode : mode_q;

    logic [W-1:0] chain;

    jtag_shift_chain #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_chain (
        .tck        (tck),
        .reset      (reset),
        .capture_en (capture_en),
        .shift_en   (shift_en),
        .instr      (chain_instr),
        .tdi        (tdi),
        .dut_output (dut_output),
        .chain      (chain)
    );

    logic                bypass_q, bypass_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [7:0]          upd_cnt_q, upd_cnt_d;
    logic [N_IN-1:0]     dut_input_q, dut_input_d;
    logic                dut_strobe_q, dut_strobe_d;
    logic                err;
    logic                len_ok;
    logic                write_update;
    logic                accept;

    assign write_update = update_en & ((mode_q == INSTR_WRITE) | (mode_q == INSTR_RW));
    assign accept       = write_update & len_ok;

`ifdef SCAN_LEN_CHECK_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (capture_en) begin
            cnt_d = '0;
        end else if (shift_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign len_ok = (cnt_q == CNT_W'(chain_len(mode_q, N_IN, N_OUT)));

    // Sticky error: set by a short/long write scan, cleared by STATUS bit 15.
    always_comb begin
        err_d = err_q;
        if (write_update && !len_ok) begin
            err_d = 1'b1;
        end else if (update_en && (mode_q == INSTR_STATUS) && status_q[STATUS_W-1]) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign len_ok = 1'b1;
    assign err    = 1'b0;
`endif

    always_comb begin
        mode_d       = mode_q;
        bypass_d     = bypass_q;
        status_d     = status_q;
        upd_cnt_d    = upd_cnt_q;
        dut_input_d  = dut_input_q;
        dut_strobe_d = accept;
        if (update_en) begin
            if (accept) begin
                dut_input_d = chain[N_IN-1:0];
                upd_cnt_d   = upd_cnt_q + 8'd1;
            end
        end else if (capture_en) begin
            mode_d = ir_mode;
            if (ir_mode == INSTR_STATUS) begin
                status_d = {err, 7'b0, upd_cnt_q};
            end
            if (ir_mode == INSTR_BYPASS) begin
                bypass_d = 1'b0;
            end
        end else if (shift_en) begin
            if (mode_q == INSTR_STATUS) begin
                status_d = {tdi, status_q[STATUS_W-1:1]};
            end
            if (mode_q == INSTR_BYPASS) begin
                bypass_d = tdi;
            end
        end
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            mode_q       <= INSTR_BYPASS;
            bypass_q     <= 1'b0;
            status_q     <= '0;
            upd_cnt_q    <= '0;
            dut_input_q  <= '0;
            dut_strobe_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            bypass_q     <= bypass_d;
            status_q     <= status_d;
            upd_cnt_q    <= upd_cnt_d;
            dut_input_q  <= dut_input_d;
            dut_strobe_q <= dut_strobe_d;
        end
    end

    always_comb begin
        case (mode_q)
            INSTR_BYPASS: tdo = bypass_q;
            INSTR_STATUS: tdo = status_q[0];
            default:      tdo = chain[0];
        endcase
    end

    assign dut_input  = dut_input_q;
    assign dut_strobe = dut_strobe_q;
    assign state_out  = {mode_q, err, dut_strobe_q};

    // Chain bits above N_IN only matter through the shift path.
    logic unused_chain;
    assign unused_chain = ^chain;

    if (IR_W > 3) begin : g_ir_upper
        logic unused_ir;
        assign unused_ir = ^ir_in[IR_W-1:3];
    end

endmodule

// File: tb/tb_jtag_scan_bridge.sv
// Self-checking bench for jtag_scan_bridge: directed vector table, randomized
// full-length scans against a scan-level reference model, and corner sequences.
module tb_jtag_scan_bridge;

    localparam int N_IN  = 8;
    localparam int N_OUT = 6;
    localparam int IR_W  = 3;
    localparam int W     = 8;

    logic             tck = 1'b0;
    logic             reset;
    logic             tdi;
    logic             tdo;
    logic [IR_W-1:0]  ir_in;
    logic             cdr, sdr, udr;
    logic [N_IN-1:0]  dut_input;
    logic [N_OUT-1:0] dut_output;
    logic             dut_strobe;
    logic [4:0]       state_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]      m_cnt;
    logic [N_IN-1:0] m_din;
    logic            m_err;

    always #5 tck = ~tck;

    jtag_scan_bridge #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .IR_W  (IR_W)
    ) dut (
        .tck        (tck),
        .reset      (reset),
        .tdi        (tdi),
        .tdo        (tdo),
        .ir_in      (ir_in),
        .cdr        (cdr),
        .sdr        (sdr),
        .udr        (udr),
        .dut_input  (dut_input),
        .dut_output (dut_output),
        .dut_strobe (dut_strobe),
        .state_out  (state_out)
    );

    typedef struct {
        logic [2:0]       code;
        logic [63:0]      tdi_word;
        logic [N_OUT-1:0] dout;
        logic [63:0]      exp_out;
        logic [N_IN-1:0]  exp_din;
        logic             exp_strobe;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    function automatic int ref_len(input logic [2:0] code);
        case (code)
            3'd1:    return N_IN;
            3'd2:    return N_OUT;
            3'd3:    return W;
            3'd4:    return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] ref_mode(input logic [2:0] code);
        return (code > 3'd4) ? 3'd0 : code;
    endfunction

    // Capture, nshift shifts (tdo recorded before each shift edge), optional update.
    task automatic applyStimulus(input logic [2:0] code, input logic [63:0] tdi_word,
                                 input int nshift, input logic [N_OUT-1:0] dout,
                                 input logic do_update, output logic [63:0] out_word);
        out_word   = '0;
        ir_in      = IR_W'(code);
        dut_output = dout;
        cdr        = 1'b1;
        tick();
        cdr = 1'b0;
        for (int k = 0; k < nshift; k++) begin
            out_word[k] = tdo;
            tdi         = tdi_word[k];
            sdr         = 1'b1;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
        if (do_update) begin
            udr = 1'b1;
            tick();
            udr = 1'b0;
        end
    endtask

    // Full-length scan with update, checked against the reference model.
    task automatic modelScan(input logic [2:0] code, input logic [63:0] tdi_word,
                             input logic [N_OUT-1:0] dout, input string tag);
        logic [63:0] got;
        logic [63:0] exp_out;
        logic        exp_strobe;
        int          len;
        len = ref_len(code);
        case (code)
            3'd2, 3'd3: exp_out = 64'(dout);
            3'd4:       exp_out = 64'({m_err, 7'b0, m_cnt});
            default:    exp_out = '0;
        endcase
        applyStimulus(code, tdi_word, len, dout, 1'b1, got);
        checkOutput({tag, " tdo"}, got, exp_out);
        exp_strobe = 1'b0;
        if (code == 3'd1 || code == 3'd3) begin
            m_din      = tdi_word[N_IN-1:0];
            m_cnt      = m_cnt + 8'd1;
            exp_strobe = 1'b1;
        end
`ifdef SCAN_LEN_CHECK_EN
        if (code == 3'd4 && tdi_word[15]) m_err = 1'b0;
`endif
        checkOutput({tag, " dut_input"}, 64'(dut_input), 64'(m_din));
        checkOutput({tag, " strobe"}, 64'(dut_strobe), 64'(exp_strobe));
        if (code <= 3'd4)
            checkOutput({tag, " state_out"}, 64'(state_out), 64'({ref_mode(code), m_err, exp_strobe}));
        else
            checkOutput({tag, " state_out lo"}, 64'(state_out[1:0]), 64'({m_err, exp_strobe}));
        tick();
        checkOutput({tag, " strobe end"}, 64'(dut_strobe), 64'h0);
    endtask

    initial begin
        logic [63:0]     got;
        logic [N_IN-1:0] held;
        logic [7:0]      bp_bits;
        logic            prev;

        reset = 1'b1; tdi = 1'b0; ir_in = '0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
        dut_output = '0;
        m_cnt = 8'd0; m_din = '0; m_err = 1'b0;

        vecs[0] = '{3'd1, 64'hA5, 6'h00, 64'h00,   8'hA5, 1'b1};
        vecs[1] = '{3'd2, 64'h00, 6'h2D, 64'h2D,   8'hA5, 1'b0};
        vecs[2] = '{3'd3, 64'h3C, 6'h13, 64'h13,   8'h3C, 1'b1};
        vecs[3] = '{3'd4, 64'h00, 6'h00, 64'h0002, 8'h3C, 1'b0};
        vecs[4] = '{3'd0, 64'h01, 6'h00, 64'h00,   8'h3C, 1'b0};

        tick(); tick();
        checkOutput("reset tdo", 64'(tdo), 64'h0);
        checkOutput("reset dut_input", 64'(dut_input), 64'h0);
        checkOutput("reset strobe", 64'(dut_strobe), 64'h0);
        checkOutput("reset state_out", 64'(state_out), 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].code, vecs[i].tdi_word, ref_len(vecs[i].code),
                          vecs[i].dout, 1'b1, got);
            checkOutput($sformatf("vec%0d tdo", i), got, vecs[i].exp_out);
            checkOutput($sformatf("vec%0d dut_input", i), 64'(dut_input), 64'(vecs[i].exp_din));
            checkOutput($sformatf("vec%0d strobe", i), 64'(dut_strobe), 64'(vecs[i].exp_strobe));
            checkOutput($sformatf("vec%0d state_out", i), 64'(state_out),
                        64'({vecs[i].code, 1'b0, vecs[i].exp_strobe}));
            tick();
            checkOutput($sformatf("vec%0d strobe end", i), 64'(dut_strobe), 64'h0);
        end
        m_din = 8'h3C;
        m_cnt = 8'd2;

        for (int i = 0; i < 40; i++) begin
            modelScan(3'($urandom_range(0, 7)), {$urandom, $urandom},
                      N_OUT'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of an RW shift with a non-zero bit on tdo.
        ir_in = IR_W'(3); dut_output = 6'h3F; cdr = 1'b1;
        tick();
        cdr = 1'b0; sdr = 1'b1; tdi = 1'b1;
        tick(); tick();
        reset = 1'b1; sdr = 1'b0;
        #1;
        checkOutput("midreset tdo", 64'(tdo), 64'h0);
        checkOutput("midreset dut_input", 64'(dut_input), 64'h0);
        checkOutput("midreset strobe", 64'(dut_strobe), 64'h0);
        checkOutput("midreset state_out", 64'(state_out), 64'h0);
        #2 reset = 1'b0;
        m_din = '0; m_cnt = 8'd0; m_err = 1'b0;
        tick();
        udr = 1'b1;
        tick();
        udr = 1'b0;
        checkOutput("post-reset udr dut_input", 64'(dut_input), 64'h0);
        checkOutput("post-reset udr strobe", 64'(dut_strobe), 64'h0);
        tick();

        for (int i = 0; i < 256; i++) begin
            modelScan(3'd1, {32'h0, $urandom}, '0, $sformatf("wr%0d", i));
        end
        applyStimulus(3'd4, 64'h0, 16, '0, 1'b1, got);
        checkOutput("status wrap", got, 64'h0000);
        tick();

        // Bypass: tdo shows the previous tdi, cleared on capture.
        bp_bits = 8'($urandom) | 8'h81;
        ir_in = IR_W'(0); cdr = 1'b1;
        tick();
        cdr  = 1'b0;
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("bypass bit%0d", k), 64'(tdo), 64'(prev));
            tdi = bp_bits[k];
            sdr = 1'b1;
            tick();
            prev = bp_bits[k];
        end
        sdr = 1'b0; tdi = 1'b0;
        tick();

`ifdef SCAN_LEN_CHECK_EN
        held = dut_input;
        applyStimulus(3'd1, 64'h5A, 7, '0, 1'b1, got);
        checkOutput("short write dut_input", 64'(dut_input), 64'(held));
        checkOutput("short write strobe", 64'(dut_strobe), 64'h0);
        checkOutput("short write err", 64'(state_out[1]), 64'h1);
        m_err = 1'b1;
        tick();
        checkOutput("short write strobe end", 64'(dut_strobe), 64'h0);
        applyStimulus(3'd4, 64'h8000, 16, '0, 1'b1, got);
        checkOutput("err status word", got, 64'({1'b1, 7'b0, m_cnt}));
        checkOutput("err cleared", 64'(state_out[1]), 64'h0);
        m_err = 1'b0;
        tick();
`else
        held = dut_input;
        applyStimulus(3'd1, 64'h5A, 7, '0, 1'b1, got);
        checkOutput("short write strobe", 64'(dut_strobe), 64'h1);
        checkOutput("short write err", 64'(state_out[1]), 64'h0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
